// File: rtl/pll_lock_rst_seq.sv
// PLL power-up / lock sequencer: powers the PLL, filters its LOCK, and holds sys_rst_o until lock is stable.
// Optional lock timeout with retry counting is built when PLL_LOCK_TIMEOUT_EN is defined.
module pll_lock_rst_seq #(
    parameter int unsigned PD_CYCLES    = 16,
    parameter int unsigned LOCK_FILTER  = 64,
    parameter int unsigned LOSS_FILTER  = 4,
    parameter int unsigned RST_HOLD     = 256,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned CNT_W        = 17
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_lock_i,
    output logic       pll_powerdown_n_o,
    output logic       sys_rst_o,
    output logic       locked_o,
    output logic       lock_lost_o,
    output logic [7:0] retry_cnt_o
);

    typedef enum logic [1:0] {
        ST_PWRDN,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RUN
    } state_e;

    localparam logic [CNT_W-1:0] PD_LAST   = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILTER - 1);
    localparam logic [CNT_W-1:0] RH_LAST   = CNT_W'(RST_HOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic             pd_n_q, pd_n_d;
    logic             sys_rst_q, sys_rst_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic             lock_s;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]       retry_q, retry_d;
`endif

    assign lock_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], pll_lock_i};
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
`ifdef PLL_LOCK_TIMEOUT_EN
        to_cnt_d = '0;
        retry_d  = retry_q;
`endif
        // cnt is the per-state counter; in RUN it counts consecutive low lock_s cycles
        case (state_q)
            ST_PWRDN: begin
                if (cnt_q == PD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LF_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == RH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Leave on the edge that samples the LOSS_FILTER-th consecutive low cycle
                if (lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PWRDN;
                    lost_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_PWRDN;
            end
        endcase

`ifdef PLL_LOCK_TIMEOUT_EN
        // Filter completion already moved state_d to HOLD, so it beats a simultaneous timeout
        if (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK) begin
            if (to_cnt_q == TO_LAST) begin
                state_d = ST_PWRDN;
                cnt_d   = '0;
                if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
            end else begin
                to_cnt_d = to_cnt_q + CNT_W'(1);
            end
        end
`endif

        pd_n_d    = (state_d != ST_PWRDN);
        sys_rst_d = (state_d != ST_RUN);
        locked_d  = (state_d == ST_HOLD) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_PWRDN;
            cnt_q     <= '0;
            sync_q    <= 2'b00;
            pd_n_q    <= 1'b0;
            sys_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            pd_n_q    <= pd_n_d;
            sys_rst_q <= sys_rst_d;
            locked_q  <= locked_d;
            lost_q    <= lost_d;
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
            retry_q  <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            retry_q  <= retry_d;
        end
    end

    assign retry_cnt_o = retry_q;
`else
    assign retry_cnt_o = 8'd0;
`endif

    assign pll_powerdown_n_o = pd_n_q;
    assign sys_rst_o         = sys_rst_q;
    assign locked_o          = locked_q;
    assign lock_lost_o       = lost_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq: directed vector table, hand-written corner sequences,
// and random LOCK waveforms checked every cycle against a run-length reference model.
module tb_pll_lock_rst_seq;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TO    = 200;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 65536;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int PD = 16, LF = 64, LOSS = 4, HOLD = 256;
    localparam int PH_PD = 0, PH_WAIT = 1, PH_HOLD = 2, PH_RUN = 3;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       pll_lock_i;
    logic       pll_powerdown_n_o, sys_rst_o, locked_o, lock_lost_o;
    logic [7:0] retry_cnt_o;

    pll_lock_rst_seq #(.LOCK_TIMEOUT(TO)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .pll_lock_i        (pll_lock_i),
        .pll_powerdown_n_o (pll_powerdown_n_o),
        .sys_rst_o         (sys_rst_o),
        .locked_o          (locked_o),
        .lock_lost_o       (lock_lost_o),
        .retry_cnt_o       (retry_cnt_o)
    );

    always #20 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus run lengths; lock_s is the LOCK sample from two edges ago
    int m_ph, m_age, m_hi, m_to, m_lo, m_retry;
    bit m_lost, m_h1, m_h2;

    task automatic model_reset();
        m_ph = PH_PD; m_age = 0; m_hi = 0; m_to = 0; m_lo = 0; m_retry = 0;
        m_lost = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0;
    endtask

    task automatic model_step(input bit lk);
        bit ls;
        ls = m_h2; m_h2 = m_h1; m_h1 = lk;
        case (m_ph)
            PH_PD: begin
                m_age++;
                if (m_age == PD) begin m_ph = PH_WAIT; m_hi = 0; m_to = 0; end
            end
            PH_WAIT: begin
                m_hi = ls ? m_hi + 1 : 0;
                m_to++;
                if (m_hi == LF) begin
                    m_ph = PH_HOLD; m_age = 0;
                end else if (TO_EN && m_to == TO) begin
                    m_ph = PH_PD; m_age = 0;
                    if (m_retry < 255) m_retry++;
                end
            end
            PH_HOLD: begin
                if (!ls) begin
                    m_ph = PH_WAIT; m_hi = 0; m_to = 0;
                end else begin
                    m_age++;
                    if (m_age == HOLD) begin m_ph = PH_RUN; m_lo = 0; end
                end
            end
            default: begin
                m_lo = ls ? 0 : m_lo + 1;
                if (m_lo == LOSS) begin m_ph = PH_PD; m_age = 0; m_lost = 1'b1; end
            end
        endcase
    endtask

    function automatic logic [11:0] model_vec();
        return {m_ph != PH_PD, m_ph != PH_RUN, m_ph >= PH_HOLD, m_lost, 8'(m_retry)};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {pll_powerdown_n_o, sys_rst_o, locked_o, lock_lost_o, retry_cnt_o};
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pd_n/srst/lkd/lost/retry=%b_%h expected %b_%h at %0t",
                     nm, act[11:8], act[7:0], exp[11:8], exp[7:0], $time);
        end
    endtask

    // One clock: drive LOCK at the falling edge, step model at the rising edge, compare at next fall
    task automatic cyc(input bit lk);
        pll_lock_i = lk;
        @(posedge clk_i);
        model_step(lk);
        @(negedge clk_i);
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        pll_lock_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    typedef struct {
        bit         lk;
        int         n;
        logic [3:0] exp;   // {pd_n, sys_rst, locked, lock_lost}
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b0, 15,  4'b0100};  // POWERDOWN low for 15 cycles
        tbl[1]  = '{1'b0, 1,   4'b1100};  // released on the 16th
        tbl[2]  = '{1'b1, 1,   4'b1100};
        tbl[3]  = '{1'b1, 64,  4'b1100};
        tbl[4]  = '{1'b1, 1,   4'b1110};  // locked on the 66th edge of high LOCK
        tbl[5]  = '{1'b1, 255, 4'b1110};
        tbl[6]  = '{1'b1, 1,   4'b1010};  // reset released 256 cycles after lock
        tbl[7]  = '{1'b0, 3,   4'b1010};  // 3-cycle dropout ignored
        tbl[8]  = '{1'b1, 4,   4'b1010};
        tbl[9]  = '{1'b0, 5,   4'b1010};  // only 3 lows seen through the synchroniser
        tbl[10] = '{1'b0, 1,   4'b0101};  // 4th low: loss declared
        tbl[11] = '{1'b1, 15,  4'b0101};
        tbl[12] = '{1'b1, 1,   4'b1101};
        tbl[13] = '{1'b1, 63,  4'b1101};
        tbl[14] = '{1'b1, 1,   4'b1111};

        rst_i = 1'b1;
        pll_lock_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("reset_state", dut_vec(), 12'b0100_0000_0000);
        rst_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].lk);
            chk($sformatf("tbl[%0d]", i), dut_vec(), {tbl[i].exp, 8'h00});
        end

        // HOLD: a one-cycle dropout returns to WAIT_LOCK with the PLL still powered
        repeat (98) cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        chk("hold_drop_pre", dut_vec(), 12'b1111_0000_0000);
        cyc(1'b1);
        chk("hold_drop_wait", dut_vec(), 12'b1101_0000_0000);

        // WAIT_LOCK: glitch after 40 highs restarts the filter
        repeat (40) cyc(1'b1);
        cyc(1'b0);
        repeat (65) cyc(1'b1);
        chk("glitch_not_yet", dut_vec(), 12'b1101_0000_0000);
        cyc(1'b1);
        chk("glitch_relock", dut_vec(), 12'b1111_0000_0000);
        repeat (255) cyc(1'b1);
        chk("hold_end", dut_vec(), 12'b1111_0000_0000);
        cyc(1'b1);
        chk("run_entry", dut_vec(), 12'b1011_0000_0000);

        // Asynchronous reset in RUN
        repeat (10) cyc(1'b1);
        #5 rst_i = 1'b1;
        #1 chk("async_reset", dut_vec(), 12'b0100_0000_0000);
        model_reset();
        pll_lock_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc(1'b1);
        chk("lost_cleared", dut_vec(), 12'b0100_0000_0000);

        // Random LOCK waveforms against the model
        begin
            bit lvl;
            int left;
            lvl = 1'b1;
            left = 20000;
            while (left > 0) begin
                int len;
                if (lvl) len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(100, 800);
                else     len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(7, 300);
                if (len > left) len = left;
                for (int k = 0; k < len; k++) cyc(lvl);
                left -= len;
                lvl = ~lvl;
            end
        end

        do_reset();
`ifdef PLL_LOCK_TIMEOUT_EN
        repeat (PD + TO - 1) cyc(1'b0);
        chk("timeout_pre", dut_vec(), 12'b1100_0000_0000);
        cyc(1'b0);
        chk("timeout_1", dut_vec(), 12'b0100_0000_0001);
        repeat (PD + TO) cyc(1'b0);
        chk("timeout_2", dut_vec(), 12'b0100_0000_0010);
        repeat (256 * (PD + TO)) cyc(1'b0);
        chk("retry_sat", dut_vec(), 12'b0100_1111_1111);
`else
        repeat (2000) cyc(1'b0);
        chk("no_timeout", dut_vec(), 12'b1100_0000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
